// File: rtl/mio_pkg.sv
// Shared constants for the memory/IO bus controller: region codes,
// peripheral register offsets and the controller FSM encoding.
package mio_pkg;
    localparam logic [3:0]  REG_GPIO  = 4'hE;
    localparam logic [3:0]  REG_TIMER = 4'hF;

    localparam logic [27:0] GPIO_LED  = 28'h0;
    localparam logic [27:0] GPIO_SW   = 28'h4;
    localparam logic [27:0] TIMER_CNT = 28'h0;

    // Wide enough for RAM_WAIT up to 15
    localparam int WAIT_W = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RAM_ACC = 2'd1,
        DONE    = 2'd2
    } state_e;
endpackage

// File: rtl/mio_bus_ctrl_if.sv
// CPU-side request/response bundle between the control FSM/datapath
// (master) and the memory/IO bus controller (slave).
interface mio_bus_if;
    logic        MemRead;
    logic        MemWrite;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        MIO_ready;
    logic        bus_err;

    modport master (output MemRead, MemWrite, addr, wdata,
                    input  rdata, MIO_ready, bus_err);
    modport slave  (input  MemRead, MemWrite, addr, wdata,
                    output rdata, MIO_ready, bus_err);
endinterface

// File: rtl/mio_timer.sv
// 32-bit free-running counter; a load replaces the increment in that cycle.
module mio_timer (
    input  logic        clk,
    input  logic        reset,
    input  logic        ld,
    input  logic [31:0] ld_val,
    output logic [31:0] cnt
);
    logic [31:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = ld ? ld_val : cnt_q + 32'd1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign cnt = cnt_q;
endmodule

// File: rtl/mio_bus_ctrl.sv
// Memory/IO bus controller: decodes CPU requests into RAM, GPIO or timer,
// inserts RAM wait states and pulses MIO_ready once per completed access.
module mio_bus_ctrl
    import mio_pkg::*;
#(
    parameter int RAM_AW   = 10,
    parameter int RAM_WAIT = 2,
    parameter int GPIO_W   = 16
) (
    input  logic              clk,
    input  logic              reset,
    mio_bus_if.slave          bus,
    output logic              ram_en,
    output logic              ram_we,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [31:0]       ram_din,
    input  logic [31:0]       ram_dout,
    output logic [GPIO_W-1:0] led,
    input  logic [GPIO_W-1:0] sw
);
    state_e              state_q, state_d;
    logic [WAIT_W-1:0]   wcnt_q, wcnt_d;
    logic [31:0]         rdata_q, rdata_d;
    logic                rdy_q, rdy_d;
    logic                err_q, err_d;
    logic                ram_en_q, ram_en_d;
    logic                ram_we_q, ram_we_d;
    logic [RAM_AW-1:0]   ram_addr_q, ram_addr_d;
    logic [31:0]         ram_din_q, ram_din_d;
    logic                acc_wr_q, acc_wr_d;
    logic [GPIO_W-1:0]   led_q, led_d;
    logic [GPIO_W-1:0]   sw_s1_q, sw_s2_q;

    logic [3:0]  region;
    logic [27:0] off;
    logic        req, is_gpio, is_timer, is_ram;
    logic        tmr_ld;
    logic [31:0] tmr_cnt;
    logic [31:0] per_rdata;

    // Low address bits are dropped so misaligned accesses hit the enclosing word
    assign region   = bus.addr[31:28];
    assign off      = {bus.addr[27:2], 2'b00};
    assign req      = bus.MemRead | bus.MemWrite;
    assign is_gpio  = (region == REG_GPIO);
    assign is_timer = (region == REG_TIMER);
    assign is_ram   = !is_gpio && !is_timer;
    assign tmr_ld   = (state_q == IDLE) && bus.MemWrite && is_timer && (off == TIMER_CNT);

    mio_timer u_timer (
        .clk    (clk),
        .reset  (reset),
        .ld     (tmr_ld),
        .ld_val (bus.wdata),
        .cnt    (tmr_cnt)
    );

    always_comb begin
        per_rdata = '0;
        if (is_gpio && off == GPIO_LED)        per_rdata = 32'(led_q);
        else if (is_gpio && off == GPIO_SW)    per_rdata = 32'(sw_s2_q);
        else if (is_timer && off == TIMER_CNT) per_rdata = tmr_cnt;
    end

    always_comb begin
        state_d    = state_q;
        wcnt_d     = wcnt_q;
        rdata_d    = rdata_q;
        err_d      = 1'b0;
        ram_en_d   = 1'b0;
        ram_we_d   = 1'b0;
        ram_addr_d = ram_addr_q;
        ram_din_d  = ram_din_q;
        acc_wr_d   = acc_wr_q;
        led_d      = led_q;
        case (state_q)
            IDLE: begin
                if (req) begin
                    err_d = (bus.MemRead && bus.MemWrite) || (bus.addr[1:0] != 2'b00);
                    if (is_ram) begin
                        state_d    = RAM_ACC;
                        wcnt_d     = WAIT_W'(RAM_WAIT);
                        ram_en_d   = 1'b1;
                        ram_we_d   = bus.MemWrite;
                        ram_addr_d = bus.addr[RAM_AW+1:2];
                        ram_din_d  = bus.wdata;
                        acc_wr_d   = bus.MemWrite;
                    end else begin
                        state_d = DONE;
                        if (bus.MemWrite) begin
                            if (is_gpio && off == GPIO_LED) led_d = bus.wdata[GPIO_W-1:0];
                        end else begin
                            rdata_d = per_rdata;
                        end
                    end
                end
            end
            RAM_ACC: begin
                if (wcnt_q == '0) begin
                    state_d = DONE;
                    if (!acc_wr_q) rdata_d = ram_dout;
                end else begin
                    wcnt_d = wcnt_q - WAIT_W'(1);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        rdy_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            wcnt_q     <= '0;
            rdata_q    <= '0;
            rdy_q      <= 1'b0;
            err_q      <= 1'b0;
            ram_en_q   <= 1'b0;
            ram_we_q   <= 1'b0;
            ram_addr_q <= '0;
            ram_din_q  <= '0;
            acc_wr_q   <= 1'b0;
            led_q      <= '0;
            sw_s1_q    <= '0;
            sw_s2_q    <= '0;
        end else begin
            state_q    <= state_d;
            wcnt_q     <= wcnt_d;
            rdata_q    <= rdata_d;
            rdy_q      <= rdy_d;
            err_q      <= err_d;
            ram_en_q   <= ram_en_d;
            ram_we_q   <= ram_we_d;
            ram_addr_q <= ram_addr_d;
            ram_din_q  <= ram_din_d;
            acc_wr_q   <= acc_wr_d;
            led_q      <= led_d;
            sw_s1_q    <= sw;
            sw_s2_q    <= sw_s1_q;
        end
    end

    assign bus.rdata     = rdata_q;
    assign bus.MIO_ready = rdy_q;
    assign bus.bus_err   = err_q;
    assign ram_en        = ram_en_q;
    assign ram_we        = ram_we_q;
    assign ram_addr      = ram_addr_q;
    assign ram_din       = ram_din_q;
    assign led           = led_q;
endmodule

// File: doc/mio_bus_ctrl.md
Name: mio_bus_ctrl

Overview:
- Memory/IO bus controller between the multi-cycle CPU datapath/control FSM and the word RAM plus on-chip peripherals.
- Accepts level-held MemRead/MemWrite requests and decodes the address into RAM, GPIO or timer regions.
- Inserts RAM wait states and returns read data.
- Pulses MIO_ready once per completed access; the control FSM waits for this pulse before leaving a memory state.

Parameters:
- RAM_AW, 10, RAM word-address width (RAM depth = 2^RAM_AW words).
- RAM_WAIT, 2, extra cycles between RAM enable and valid ram_dout. Legal range 0..15.
- GPIO_W, 16, width of the LED output register and the switch input.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- MemRead  in  1  read request, held high until MIO_ready is seen.
- MemWrite  in  1  write request, held high until MIO_ready is seen.
- addr  in  32  byte address from the datapath.
- wdata  in  32  write data.
- rdata  out  32  read data, registered, valid in the MIO_ready cycle.
- MIO_ready  out  1  one-cycle completion pulse.
- bus_err  out  1  one-cycle pulse: MemRead and MemWrite both high, or misaligned address.
- ram_en  out  1  RAM enable.
- ram_we  out  1  RAM write enable.
- ram_addr  out  RAM_AW  RAM word address, equal to addr[RAM_AW+1:2].
- ram_din  out  32  RAM write data.
- ram_dout  in  32  RAM read data.
- led  out  GPIO_W  LED register.
- sw  in  GPIO_W  asynchronous switch inputs.

Behaviour:
- Reset (reset=0, async): state=IDLE; rdata=0; MIO_ready=0; bus_err=0; ram_en=0; ram_we=0; led=0; timer=0; wait counter=0; switch synchronisers=0.
- Address decode, on addr[31:28]:
  - 4'hE: GPIO. Offset 0x0 is led (R/W). Offset 0x4 is sw (read-only, writes ignored).
  - 4'hF: timer. Offset 0x0 is the 32-bit free-running counter (R/W).
  - All other values: RAM.
  - Unmapped GPIO/timer offsets: read 0, write ignored.
- Request handling:
  - Requests are sampled only in IDLE.
  - If MemWrite=1 in IDLE, the access is a write, even if MemRead=1 too (bus_err pulses in that case).
  - addr[1:0]!=0 forces word alignment and pulses bus_err. The access still completes.
- FSM states: IDLE, RAM_ACC, DONE.
  - IDLE, request to RAM: drive ram_en=1, ram_we=write, ram_addr, ram_din for exactly one cycle. Load the wait counter with RAM_WAIT. Go to RAM_ACC.
  - IDLE, request to GPIO/timer/unmapped: perform the register write or capture rdata at this edge. Go to DONE.
  - RAM_ACC: decrement the counter each cycle. When the counter reaches 0, capture ram_dout into rdata (reads only) and go to DONE. With RAM_WAIT=0, RAM_ACC lasts one cycle.
  - DONE: MIO_ready=1 for exactly this cycle, then go to IDLE. rdata holds until the next read completes.
- Write transactions: rdata is left unchanged.
- Latency from request sampled in IDLE to MIO_ready high:
  - Peripheral access: 1 cycle.
  - RAM access: RAM_WAIT+2 cycles.
- Back-to-back: a request still high in the IDLE cycle right after DONE starts a new access. The control FSM deasserts its request on the MIO_ready edge, so no duplicate access occurs.
- Timer:
  - Increments every clock, wrapping 0xFFFFFFFF to 0.
  - A timer write loads wdata. The write takes precedence over the increment in the same cycle.
- Switches: sw passes through a 2-flop synchroniser. Reads return the synchronised value, zero-extended to 32 bits.
- led: written with wdata[GPIO_W-1:0].
- Reset mid-access: returns to IDLE immediately. No MIO_ready is produced for the aborted access. ram_en/ram_we drop asynchronously.

Decomposition:
- Shared package mio_pkg holds:
  - Region codes REG_GPIO=4'hE and REG_TIMER=4'hF.
  - Offsets GPIO_LED=0x0, GPIO_SW=0x4, TIMER_CNT=0x0.
  - FSM state encoding.
- One sub-module, mio_timer: the 32-bit counter with its load port.
- Decode, FSM and GPIO stay in mio_bus_ctrl.

Test Plan:
- RAM_WAIT=2. MemWrite, addr=0x00000010, wdata=0xDEADBEEF, then MemRead at the same addr. Required: ram_addr=4 for both accesses, MIO_ready 4 cycles after each request, rdata=0xDEADBEEF.
- MemWrite to 0xE0000000 with wdata=0x0000A5A5. Required: led=0xA5A5 and MIO_ready after 1 cycle. Then sw=0x1234 held 3 cycles and a read of 0xE0000004. Required: rdata=0x00001234.
- Write timer 0xF0000000 with 0xFFFFFFFE, then read it 2 cycles after MIO_ready. Required: value wrapped through 0, read returns 0x00000001 ±1 per cycle of skew (exact value checked against a model).
- MemRead and MemWrite both high at addr 0x00000021. Required: write performed at word 8, bus_err pulses one cycle, MIO_ready still asserted.
- reset driven to 0 during RAM_ACC. Required: ram_en=0 immediately, no MIO_ready; the following read returns the previous RAM contents.
- Read of unmapped address 0xE0000008. Required: rdata=0, MIO_ready after 1 cycle, no RAM enable.
